// File: rtl/pipe_alu_cc.sv
// Two-stage pipelined Execute ALU with valid/ready handshake, flush and a committed CC register.
// Optional build macro ALU_SAT_EN: ADD/SUB saturate on signed overflow instead of wrapping.
module pipe_alu_cc #(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_op,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_set_cc,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic             out_overflow,
  output logic             cc_zf,
  output logic             cc_sf,
  output logic             cc_of
);

  typedef enum logic [2:0] {
    OpAdd, OpSub, OpAnd, OpXor, OpOr, OpSll, OpSra, OpPassb
  } op_e;

  logic             s1_valid_q;
  op_e              s1_op_q;
  logic [WIDTH-1:0] s1_a_q;
  logic [WIDTH-1:0] s1_b_q;
  logic             s1_set_cc_q;

  logic             s2_valid_q;
  logic [WIDTH-1:0] s2_result_q;
  logic             s2_overflow_q;
  logic             s2_set_cc_q;

  logic             cc_zf_q;
  logic             cc_sf_q;
  logic             cc_of_q;

  logic             s2_adv;
  logic             s1_adv;
  logic             accept;
  logic             commit;

  logic             is_sub;
  logic [WIDTH-1:0] b_eff;
  logic [WIDTH-1:0] sum;
  logic [WIDTH-1:0] arith_res;
  logic             arith_ovf;
  logic [WIDTH-1:0] result_d;
  logic             overflow_d;

  assign s2_adv   = !s2_valid_q || out_ready;
  assign s1_adv   = s1_valid_q && s2_adv;
  assign in_ready = !s1_valid_q || s2_adv;
  assign accept   = in_valid && in_ready && !flush;
  assign commit   = s2_valid_q && out_ready;

  always_comb begin
    is_sub    = (s1_op_q == OpSub);
    b_eff     = is_sub ? ~s1_b_q : s1_b_q;
    sum       = s1_a_q + b_eff + WIDTH'(is_sub);
    // With B inverted for SUB, both cases reduce to the same-sign-operands rule.
    arith_ovf = (s1_a_q[WIDTH-1] == b_eff[WIDTH-1]) && (sum[WIDTH-1] != s1_a_q[WIDTH-1]);
    arith_res = sum;
`ifdef ALU_SAT_EN
    // Overflow direction always follows the sign of A.
    if (arith_ovf) arith_res = {s1_a_q[WIDTH-1], {(WIDTH-1){~s1_a_q[WIDTH-1]}}};
`else
    arith_res = sum;
`endif

    result_d   = '0;
    overflow_d = 1'b0;
    case (s1_op_q)
      OpAdd, OpSub: begin
        result_d   = arith_res;
        overflow_d = arith_ovf;
      end
      OpAnd:   result_d = s1_a_q & s1_b_q;
      OpXor:   result_d = s1_a_q ^ s1_b_q;
      OpOr:    result_d = s1_a_q | s1_b_q;
      OpSll:   result_d = s1_a_q << s1_b_q[SHW-1:0];
      OpSra:   result_d = WIDTH'($signed(s1_a_q) >>> s1_b_q[SHW-1:0]);
      OpPassb: result_d = s1_b_q;
      default: result_d = '0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q    <= 1'b0;
      s1_op_q       <= OpAdd;
      s1_a_q        <= '0;
      s1_b_q        <= '0;
      s1_set_cc_q   <= 1'b0;
      s2_valid_q    <= 1'b0;
      s2_result_q   <= '0;
      s2_overflow_q <= 1'b0;
      s2_set_cc_q   <= 1'b0;
      cc_zf_q       <= 1'b1;
      cc_sf_q       <= 1'b0;
      cc_of_q       <= 1'b0;
    end else begin
      if (flush) begin
        s1_valid_q <= 1'b0;
        s2_valid_q <= 1'b0;
      end else begin
        if (s2_adv)   s2_valid_q <= s1_valid_q;
        if (in_ready) s1_valid_q <= in_valid;
      end

      if (accept) begin
        s1_op_q     <= op_e'(in_op);
        s1_a_q      <= in_a;
        s1_b_q      <= in_b;
        s1_set_cc_q <= in_set_cc;
      end

      if (s1_adv && !flush) begin
        s2_result_q   <= result_d;
        s2_overflow_q <= overflow_d;
        s2_set_cc_q   <= s1_set_cc_q;
      end

      // A result leaving in the flush cycle has already committed, so it still updates CC.
      if (commit && s2_set_cc_q) begin
        cc_zf_q <= (s2_result_q == '0);
        cc_sf_q <= s2_result_q[WIDTH-1];
        cc_of_q <= s2_overflow_q;
      end
    end
  end

  assign out_valid    = s2_valid_q;
  assign out_result   = s2_result_q;
  assign out_overflow = s2_overflow_q;
  assign cc_zf        = cc_zf_q;
  assign cc_sf        = cc_sf_q;
  assign cc_of        = cc_of_q;

endmodule

// File: tb/tb_pipe_alu_cc.sv
// Self-checking bench for pipe_alu_cc: directed vectors, stalls, flush, async reset and
// randomized traffic against a queue-based reference model.
module tb_pipe_alu_cc;

  localparam logic signed [64:0] SMax = 65'sd9223372036854775807;
  localparam logic signed [64:0] SMin = -SMax - 65'sd1;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [2:0]  in_op = 3'd0;
  logic [63:0] in_a = '0;
  logic [63:0] in_b = '0;
  logic        in_set_cc = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [63:0] out_result;
  logic        out_overflow;
  logic        cc_zf, cc_sf, cc_of;

  pipe_alu_cc #(.WIDTH(64)) dut (
    .clk          (clk),
    .rst          (rst),
    .flush        (flush),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_op        (in_op),
    .in_a         (in_a),
    .in_b         (in_b),
    .in_set_cc    (in_set_cc),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_result   (out_result),
    .out_overflow (out_overflow),
    .cc_zf        (cc_zf),
    .cc_sf        (cc_sf),
    .cc_of        (cc_of)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] r;
    logic        ov;
    logic        sc;
  } exp_t;

  int          checks = 0;
  int          errors = 0;
  exp_t        exp_q[$];
  logic        m_zf = 1'b1, m_sf = 1'b0, m_of = 1'b0;
  logic        last_acc, last_com, last_exp_ok;
  logic [63:0] last_got;
  logic        last_got_ov;
  exp_t        last_exp;

  function automatic exp_t ref_op(input logic [2:0] op, input logic [63:0] a, input logic [63:0] b,
                                  input logic sc);
    exp_t e;
    logic signed [64:0] wide;
    e.ov = 1'b0;
    e.sc = sc;
    e.r  = '0;
    case (op)
      3'd0, 3'd1: begin
        wide = (op == 3'd0) ? $signed(a) + $signed(b) : $signed(a) - $signed(b);
        e.ov = (wide > SMax) || (wide < SMin);
        e.r  = wide[63:0];
`ifdef ALU_SAT_EN
        if (wide > SMax) e.r = 64'h7FFF_FFFF_FFFF_FFFF;
        if (wide < SMin) e.r = 64'h8000_0000_0000_0000;
`endif
      end
      3'd2: e.r = a & b;
      3'd3: e.r = a ^ b;
      3'd4: e.r = a | b;
      3'd5: e.r = a << b[5:0];
      3'd6: e.r = $signed(a) >>> b[5:0];
      default: e.r = b;
    endcase
    return e;
  endfunction

  // Advance one clock and keep the reference model in step with the handshake.
  task automatic tick();
    logic acc, com;
    logic [2:0] op;
    logic [63:0] a, b;
    logic sc, fl;
    @(negedge clk);
    acc = in_valid && in_ready && !flush;
    com = out_valid && out_ready;
    op = in_op; a = in_a; b = in_b; sc = in_set_cc; fl = flush;
    last_got = out_result;
    last_got_ov = out_overflow;
    @(posedge clk);
    #1;
    last_acc = acc;
    last_com = com;
    last_exp_ok = 1'b0;
    if (com && exp_q.size() > 0) begin
      last_exp = exp_q.pop_front();
      last_exp_ok = 1'b1;
      if (last_exp.sc) begin
        m_zf = (last_exp.r == 64'd0);
        m_sf = ($signed(last_exp.r) < 0);
        m_of = last_exp.ov;
      end
    end
    if (fl) exp_q.delete();
    if (acc) exp_q.push_back(ref_op(op, a, b, sc));
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (out_valid !== 1'b0 || out_result !== 64'd0 || out_overflow !== 1'b0) begin
      errors++;
      $display("FAIL reset_out: got v=%b r=%h o=%b want 0 0 0", out_valid, out_result, out_overflow);
    end
    checks++;
    if ({cc_zf, cc_sf, cc_of} !== 3'b100) begin
      errors++;
      $display("FAIL reset_cc: got %b want 100", {cc_zf, cc_sf, cc_of});
    end
    rst = 1'b0;
    tick();
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle: got rdy=%b v=%b want 1 0", in_ready, out_valid);
    end
  endtask

  task automatic test_directed();
    logic [2:0]  t_op[9] = '{3'd0, 3'd1, 3'd2, 3'd5, 3'd6, 3'd7, 3'd1, 3'd3, 3'd4};
    logic [63:0] t_a[9] = '{64'h7FFF_FFFF_FFFF_FFFF, 64'd5, 64'hF0, 64'd1, 64'h8000_0000_0000_0000,
                            64'd0, 64'h8000_0000_0000_0000, 64'hFF, 64'h8000_0000_0000_0000};
    logic [63:0] t_b[9] = '{64'd1, 64'd5, 64'h0F, 64'd63, 64'd4, 64'h1234, 64'd1, 64'h0F, 64'd1};
    logic        t_sc[9] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    logic        t_ov[9] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
`ifdef ALU_SAT_EN
    logic [63:0] t_r[9] = '{64'h7FFF_FFFF_FFFF_FFFF, 64'd0, 64'd0, 64'h8000_0000_0000_0000,
                            64'hF800_0000_0000_0000, 64'h1234, 64'h8000_0000_0000_0000, 64'hF0,
                            64'h8000_0000_0000_0001};
    logic [2:0]  t_cc[9] = '{3'b001, 3'b100, 3'b100, 3'b010, 3'b010, 3'b010, 3'b011, 3'b000, 3'b000};
`else
    logic [63:0] t_r[9] = '{64'h8000_0000_0000_0000, 64'd0, 64'd0, 64'h8000_0000_0000_0000,
                            64'hF800_0000_0000_0000, 64'h1234, 64'h7FFF_FFFF_FFFF_FFFF, 64'hF0,
                            64'h8000_0000_0000_0001};
    logic [2:0]  t_cc[9] = '{3'b011, 3'b100, 3'b100, 3'b010, 3'b010, 3'b010, 3'b001, 3'b000, 3'b000};
`endif
    out_ready = 1'b1;
    for (int i = 0; i < 9; i++) begin
      in_valid = 1'b1; in_op = t_op[i]; in_a = t_a[i]; in_b = t_b[i]; in_set_cc = t_sc[i];
      tick();
      in_valid = 1'b0;
      checks++;
      if (out_valid !== 1'b0) begin
        errors++;
        $display("FAIL dir%0d_early: got out_valid=%b want 0", i, out_valid);
      end
      tick();
      checks++;
      if (out_valid !== 1'b1 || out_result !== t_r[i] || out_overflow !== t_ov[i]) begin
        errors++;
        $display("FAIL dir%0d_result: got v=%b r=%h o=%b want 1 %h %b", i, out_valid, out_result,
                 out_overflow, t_r[i], t_ov[i]);
      end
      tick();
      checks++;
      if ({cc_zf, cc_sf, cc_of} !== t_cc[i]) begin
        errors++;
        $display("FAIL dir%0d_cc: got %b want %b", i, {cc_zf, cc_sf, cc_of}, t_cc[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [63:0] av[4], bv[4];
    logic [63:0] held;
    int idx = 0;
    int ncom = 0;
    for (int i = 0; i < 4; i++) begin
      av[i] = {$urandom, $urandom};
      bv[i] = {$urandom, $urandom};
    end
    out_ready = 1'b0;
    in_valid = 1'b1; in_op = 3'd0; in_a = av[0]; in_b = bv[0]; in_set_cc = 1'b1;
    held = '0;
    for (int c = 0; c < 3; c++) begin
      tick();
      if (last_acc) begin
        idx++;
        in_op = 3'(idx); in_a = av[idx % 4]; in_b = bv[idx % 4];
      end
      if (c == 1) held = out_result;
    end
    checks++;
    if (idx != 2 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL b2b_stall: got accepts=%0d in_ready=%b want 2 0", idx, in_ready);
    end
    checks++;
    if (out_valid !== 1'b1 || out_result !== held || exp_q.size() == 0 || out_result !== exp_q[0].r)
    begin
      errors++;
      $display("FAIL b2b_hold: got v=%b r=%h want 1 %h", out_valid, out_result, held);
    end
    out_ready = 1'b1;
    for (int c = 0; c < 20 && ncom < 4; c++) begin
      tick();
      if (last_acc) begin
        idx++;
        if (idx < 4) begin
          in_op = 3'(idx); in_a = av[idx]; in_b = bv[idx];
        end else begin
          in_valid = 1'b0;
        end
      end
      if (last_com) begin
        ncom++;
        checks++;
        if (!last_exp_ok || last_got !== last_exp.r || last_got_ov !== last_exp.ov) begin
          errors++;
          $display("FAIL b2b_commit%0d: got %h/%b want %h/%b", ncom, last_got, last_got_ov,
                   last_exp.r, last_exp.ov);
        end
      end
    end
    in_valid = 1'b0;
    checks++;
    if (ncom != 4) begin
      errors++;
      $display("FAIL b2b_count: got %0d commits want 4", ncom);
    end
  endtask

  task automatic test_flush();
    logic [2:0] cc_before;
    int nvalid = 0;
    tick();
    cc_before = {cc_zf, cc_sf, cc_of};
    out_ready = 1'b0;
    in_valid = 1'b1; in_op = 3'd7; in_a = '0; in_b = 64'd0; in_set_cc = 1'b1;
    tick();
    in_b = 64'h8000_0000_0000_0000;
    tick();
    in_b = 64'h55; flush = 1'b1;
    tick();
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    for (int c = 0; c < 6; c++) begin
      tick();
      if (out_valid || last_com) nvalid++;
    end
    checks++;
    if (nvalid != 0) begin
      errors++;
      $display("FAIL flush_pulses: got %0d want 0", nvalid);
    end
    checks++;
    if ({cc_zf, cc_sf, cc_of} !== cc_before) begin
      errors++;
      $display("FAIL flush_cc: got %b want %b", {cc_zf, cc_sf, cc_of}, cc_before);
    end
  endtask

  task automatic test_reset_mid();
    int nvalid = 0;
    out_ready = 1'b1;
    in_valid = 1'b1; in_op = 3'd0; in_a = '1; in_b = '0; in_set_cc = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    out_ready = 1'b0; in_valid = 1'b1; in_b = 64'd3;
    tick();
    in_valid = 1'b0;
    tick();
    checks++;
    if (out_valid !== 1'b1 || {cc_zf, cc_sf, cc_of} !== 3'b010) begin
      errors++;
      $display("FAIL rstmid_pre: got v=%b cc=%b want 1 010", out_valid, {cc_zf, cc_sf, cc_of});
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if (out_valid !== 1'b0 || {cc_zf, cc_sf, cc_of} !== 3'b100) begin
      errors++;
      $display("FAIL rstmid_async: got v=%b cc=%b want 0 100", out_valid, {cc_zf, cc_sf, cc_of});
    end
    exp_q.delete();
    m_zf = 1'b1; m_sf = 1'b0; m_of = 1'b0;
    @(posedge clk);
    #1 rst = 1'b0;
    out_ready = 1'b1;
    for (int c = 0; c < 5; c++) begin
      tick();
      if (out_valid) nvalid++;
    end
    checks++;
    if (nvalid != 0) begin
      errors++;
      $display("FAIL rstmid_spurious: got %0d valid cycles want 0", nvalid);
    end
  endtask

  task automatic test_random();
    logic [63:0] edge_v[4] = '{64'h7FFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000, 64'd0, '1};
    for (int c = 0; c < 400; c++) begin
      in_valid  = ($urandom_range(9) < 7);
      in_op     = 3'($urandom_range(7));
      in_a      = ($urandom_range(3) == 0) ? edge_v[$urandom_range(3)] : {$urandom, $urandom};
      in_b      = ($urandom_range(3) == 0) ? edge_v[$urandom_range(3)] : {$urandom, $urandom};
      in_set_cc = $urandom_range(1) == 1;
      out_ready = ($urandom_range(9) < 7);
      flush     = ($urandom_range(19) == 0);
      tick();
      if (last_com) begin
        checks++;
        if (!last_exp_ok || last_got !== last_exp.r || last_got_ov !== last_exp.ov) begin
          errors++;
          $display("FAIL rand_commit c%0d: got %h/%b want %h/%b", c, last_got, last_got_ov,
                   last_exp.r, last_exp.ov);
        end
      end
      checks++;
      if ({cc_zf, cc_sf, cc_of} !== {m_zf, m_sf, m_of}) begin
        errors++;
        $display("FAIL rand_cc c%0d: got %b want %b", c, {cc_zf, cc_sf, cc_of}, {m_zf, m_sf, m_of});
      end
    end
    in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
    for (int c = 0; c < 10 && exp_q.size() > 0; c++) begin
      tick();
      if (last_com) begin
        checks++;
        if (!last_exp_ok || last_got !== last_exp.r || last_got_ov !== last_exp.ov) begin
          errors++;
          $display("FAIL rand_drain: got %h/%b want %h/%b", last_got, last_got_ov, last_exp.r,
                   last_exp.ov);
        end
      end
    end
    checks++;
    if (exp_q.size() != 0 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL rand_empty: got %0d pending v=%b want 0 0", exp_q.size(), out_valid);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_directed();
    test_flush();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
